// File: rtl/pulse_pkg.sv
// Shared types and reset defaults for the pulse-train generator.
package pulse_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    CONT    = 1'b0,
    ONESHOT = 1'b1
  } mode_t;

  localparam int unsigned DEF_PERIOD_C = 2;
  localparam int unsigned DEF_WIDTH_C  = 1;
  localparam mode_t       DEF_MODE_C   = CONT;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One pulse-train channel: shadow/active config, period counter, two-state FSM.
module pulse_channel
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
  parameter int unsigned DEF_WIDTH  = DEF_WIDTH_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic             cfg_oneshot_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_W = CNT_W'(DEF_WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_p_q, sh_p_d, sh_w_q, sh_w_d;
  mode_t            sh_m_q, sh_m_d;
  logic [CNT_W-1:0] ac_p_q, ac_p_d, ac_w_q, ac_w_d;
  mode_t            ac_m_q, ac_m_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] eff_p, eff_w, cnt_inc;
  mode_t            eff_m;

  // Next-state: a same-cycle config write is visible to start and to the period reload.
  always_comb begin
    eff_p   = cfg_we_i ? cfg_period_i : sh_p_q;
    eff_w   = cfg_we_i ? cfg_width_i : sh_w_q;
    eff_m   = cfg_we_i ? (cfg_oneshot_i ? ONESHOT : CONT) : sh_m_q;
    cnt_inc = cnt_q + ONE;

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_p_d  = eff_p;
    sh_w_d  = eff_w;
    sh_m_d  = eff_m;
    ac_p_d  = ac_p_q;
    ac_w_d  = ac_w_q;
    ac_m_d  = ac_m_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          if (start_i) begin
            ac_p_d = eff_p;
            ac_w_d = eff_w;
            ac_m_d = eff_m;
            if (eff_p == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = RUN;
              cnt_d   = '0;
              pulse_d = (eff_w != '0);
              busy_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt_q < ac_p_q - ONE) begin
            cnt_d   = cnt_inc;
            pulse_d = (cnt_inc < ac_w_q);
          end else if (ac_m_q == CONT) begin
            cnt_d = '0;
            if (eff_p == '0) begin
              err_d   = 1'b1;
              pulse_d = (ac_w_q != '0);
            end else begin
              ac_p_d  = eff_p;
              ac_w_d  = eff_w;
              ac_m_d  = eff_m;
              pulse_d = (eff_w != '0);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_p_q  <= RST_P;
      sh_w_q  <= RST_W;
      sh_m_q  <= DEF_MODE_C;
      ac_p_q  <= RST_P;
      ac_w_q  <= RST_W;
      ac_m_q  <= DEF_MODE_C;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_p_q  <= sh_p_d;
      sh_w_q  <= sh_w_d;
      sh_m_q  <= sh_m_d;
      ac_p_q  <= ac_p_d;
      ac_w_q  <= ac_w_d;
      ac_m_q  <= ac_m_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: config decode plus CHANNELS independent channels.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
  parameter int unsigned DEF_WIDTH  = DEF_WIDTH_C
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_we,
  input  logic [sel_width(CHANNELS)-1:0]      cfg_ch,
  input  logic [CNT_W-1:0]                    cfg_period,
  input  logic [CNT_W-1:0]                    cfg_width,
  input  logic                                cfg_oneshot,
  input  logic [CHANNELS-1:0]                 start,
  input  logic [CHANNELS-1:0]                 stop,
  output logic [CHANNELS-1:0]                 pulse,
  output logic [CHANNELS-1:0]                 busy,
  output logic [CHANNELS-1:0]                 done,
  output logic [CHANNELS-1:0]                 err
);

  localparam int unsigned SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0] ch_we;

  // Per-channel write enables; a select beyond the last channel matches nothing.
  always_comb begin
    ch_we = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      ch_we[i] = cfg_we && (cfg_ch == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_WIDTH  (DEF_WIDTH)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_we_i      (ch_we[g]),
      .cfg_period_i  (cfg_period),
      .cfg_width_i   (cfg_width),
      .cfg_oneshot_i (cfg_oneshot),
      .start_i       (start[g]),
      .stop_i        (stop[g]),
      .pulse_o       (pulse[g]),
      .busy_o        (busy[g]),
      .done_o        (done[g]),
      .err_o         (err[g])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed scenarios plus random traffic against a timestamp model.
module tb_pulse_train_gen;

  localparam int CH = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_width;
  logic          cfg_oneshot;
  logic [CH-1:0] start;
  logic [CH-1:0] stop;
  logic [CH-1:0] pulse;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;
  logic [CH-1:0] err;

  pulse_train_gen #(
    .CHANNELS   (CH),
    .CNT_W      (CW),
    .DEF_PERIOD (2),
    .DEF_WIDTH  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_width   (cfg_width),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers the edge index its current period began.
  int sh_p[CH], sh_w[CH], sh_m[CH];
  int ac_p[CH], ac_w[CH], ac_m[CH];
  int pstart[CH];
  bit run[CH];
  int now = 0;
  logic [CH-1:0] exp_pulse, exp_busy, exp_done, exp_err;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      sh_p[i] = 2; sh_w[i] = 1; sh_m[i] = 0;
      ac_p[i] = 2; ac_w[i] = 1; ac_m[i] = 0;
      run[i]  = 1'b0;
      pstart[i] = 0;
    end
    exp_pulse = '0; exp_busy = '0; exp_done = '0; exp_err = '0;
  endtask

  task automatic model_step();
    now++;
    for (int i = 0; i < CH; i++) begin
      bit wr;
      int ep, ew, em;
      wr = cfg_we && (int'(cfg_ch) == i);
      ep = wr ? int'(cfg_period) : sh_p[i];
      ew = wr ? int'(cfg_width)  : sh_w[i];
      em = wr ? int'(cfg_oneshot) : sh_m[i];
      exp_done[i] = 1'b0;
      exp_err[i]  = 1'b0;
      if (stop[i]) begin
        run[i] = 1'b0;
      end else if (!run[i]) begin
        if (start[i]) begin
          ac_p[i] = ep; ac_w[i] = ew; ac_m[i] = em;
          if (ep == 0) exp_err[i] = 1'b1;
          else begin
            run[i] = 1'b1;
            pstart[i] = now;
          end
        end
      end else if (now - pstart[i] == ac_p[i]) begin
        if (ac_m[i] == 0) begin
          pstart[i] = now;
          if (ep == 0) exp_err[i] = 1'b1;
          else begin
            ac_p[i] = ep; ac_w[i] = ew; ac_m[i] = em;
          end
        end else begin
          run[i] = 1'b0;
          exp_done[i] = 1'b1;
        end
      end
      sh_p[i] = ep; sh_w[i] = ew; sh_m[i] = em;
      exp_busy[i]  = run[i];
      exp_pulse[i] = run[i] && ((now - pstart[i]) < ac_w[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("pulse", 32'(pulse), 32'(exp_pulse));
    check("busy",  32'(busy),  32'(exp_busy));
    check("done",  32'(done),  32'(exp_done));
    check("err",   32'(err),   32'(exp_err));
  endtask

  task automatic write_cfg(input int ch, input int p, input int w, input bit os);
    cfg_we = 1'b1; cfg_ch = 2'(ch);
    cfg_period = CW'(p); cfg_width = CW'(w); cfg_oneshot = os;
  endtask

  logic [7:0] ch2_pat;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_width = '0;
    cfg_oneshot = 1'b0; start = '0; stop = '0;
    model_reset();

    tick(); tick();
    check("rst_pulse", 32'(pulse), 0);
    check("rst_busy",  32'(busy),  0);
    rst_n = 1'b1;
    tick();

    // ch0 with reset defaults: 1,0,1,0
    start[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = '0;
      check("ch0_pat",  32'(pulse[0]), 32'(k % 2));
      check("ch0_busy", 32'(busy[0]), 1);
      check("ch0_done", 32'(done[0]), 0);
    end

    // ch1 one-shot P=5 W=2
    write_cfg(1, 5, 2, 1'b1);
    tick();
    cfg_we = 1'b0;
    start[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = '0;
      check("ch1_pulse", 32'(pulse[1]), 32'(k <= 2));
      check("ch1_done",  32'(done[1]),  32'(k == 6));
      check("ch1_busy",  32'(busy[1]),  32'(k <= 5));
    end

    // ch2 P=4: width change mid-period lands at the boundary
    write_cfg(2, 4, 1, 1'b0);
    tick();
    cfg_we = 1'b0;
    ch2_pat = 8'b0111_0001;
    for (int k = 1; k <= 8; k++) begin
      start[2] = (k == 1);
      if (k == 3) write_cfg(2, 4, 3, 1'b0);
      else cfg_we = 1'b0;
      tick();
      check("ch2_width", 32'(pulse[2]), 32'(ch2_pat[k-1]));
    end
    start = '0; cfg_we = 1'b0; stop[2] = 1'b1; stop[0] = 1'b1;
    tick();
    stop = '0;

    // ch3 edge cases
    write_cfg(3, 3, 0, 1'b0); start[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(); start = '0; cfg_we = 1'b0;
      check("ch3_w0", 32'(pulse[3]), 0);
    end
    stop[3] = 1'b1; tick(); stop = '0;
    write_cfg(3, 3, 7, 1'b0); start[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(); start = '0; cfg_we = 1'b0;
      check("ch3_wbig", 32'(pulse[3]), 1);
    end
    stop[3] = 1'b1; tick(); stop = '0;
    write_cfg(3, 0, 1, 1'b0); start[3] = 1'b1;
    tick(); start = '0; cfg_we = 1'b0;
    check("ch3_err", 32'(err[3]), 1);
    check("ch3_err_busy", 32'(busy[3]), 0);
    tick();
    check("ch3_err_once", 32'(err[3]), 0);

    // start and stop together on idle ch3
    write_cfg(3, 3, 1, 1'b0); tick(); cfg_we = 1'b0;
    start[3] = 1'b1; stop[3] = 1'b1;
    tick(); start = '0; stop = '0;
    check("ss_busy", 32'(busy[3]), 0);
    tick();
    check("ss_busy2", 32'(busy[3]), 0);

    // stop mid one-shot on ch1 (still P=5 W=2 one-shot)
    start[1] = 1'b1; tick(); start = '0; tick();
    stop[1] = 1'b1; tick(); stop = '0;
    check("stop_pulse", 32'(pulse[1]), 0);
    check("stop_busy",  32'(busy[1]),  0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("stop_nodone", 32'(done[1]), 0);
    end

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_ch      = 2'($urandom_range(0, 3));
      cfg_period  = CW'($urandom_range(0, 6));
      cfg_width   = CW'($urandom_range(0, 8));
      cfg_oneshot = 1'($urandom_range(0, 1));
      for (int i = 0; i < CH; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        stop[i]  = ($urandom_range(0, 29) == 0);
      end
      tick();
    end
    cfg_we = 1'b0; start = '0; stop = '0;

    // asynchronous reset mid-run, then ch1 back at defaults
    stop = '1; tick(); stop = '0;
    write_cfg(1, 3, 2, 1'b1); start = '1; tick();
    cfg_we = 1'b0; start = '0; tick();
    check("pre_rst_busy1", 32'(busy[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", 32'(pulse), 0);
    check("arst_busy",  32'(busy),  0);
    check("arst_done",  32'(done),  0);
    check("arst_err",   32'(err),   0);
    model_reset();
    tick();
    rst_n = 1'b1;
    start[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = '0;
      check("post_rst_pat",  32'(pulse[1]), 32'(k % 2));
      check("post_rst_busy", 32'(busy[1]), 1);
      check("post_rst_done", 32'(done[1]), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Multi-channel, synthesizable pulse-train generator with programmable period, high width and mode per channel. It is the clocked successor of the free-running behavioural clock/pulse pair: every waveform is derived from a single `clk` and counted in whole cycles, so the outputs can drive real logic. Each channel runs independently from a shared configuration port and per-channel start/stop strobes.

## Interface
- `CHANNELS`, 4, number of independent channels (1..16)
- `CNT_W`, 8, width of period/width counters
- `DEF_PERIOD`, 2, period loaded at reset (cycles)
- `DEF_WIDTH`, 1, high width loaded at reset (cycles)
- `clk`  in  1  sole clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  write config for channel `cfg_ch`
- `cfg_ch`  in  $clog2(CHANNELS) (min 1)  target channel
- `cfg_period`  in  CNT_W  period P in cycles
- `cfg_width`  in  CNT_W  high width W in cycles
- `cfg_oneshot`  in  1  0 = continuous, 1 = one-shot
- `start`  in  CHANNELS  per-channel start strobe
- `stop`  in  CHANNELS  per-channel abort strobe
- `pulse`  out  CHANNELS  registered waveform
- `busy`  out  CHANNELS  channel running
- `done`  out  CHANNELS  one-cycle one-shot completion
- `err`  out  CHANNELS  one-cycle strobe: start refused (P = 0)

## Operation
- Per channel: shadow config (P, W, mode) and active config. States `IDLE`, `RUN`. Counter `cnt` 0..P-1.
- Reset: all outputs 0; shadow and active = `DEF_PERIOD`, `DEF_WIDTH`, continuous; state `IDLE`; `cnt` = 0.
- `cfg_we` writes the shadow of `cfg_ch`; `cfg_ch` >= CHANNELS is ignored.
- `start` in `IDLE`: shadow copied to active. If P = 0: stay `IDLE`, `err` = 1 for one cycle. Otherwise go `RUN`, `cnt` = 0, `pulse` = (W != 0), `busy` = 1.
- `RUN`, `cnt` < P-1: `cnt`+1, `pulse` = (`cnt`+1 < W).
- `RUN`, `cnt` = P-1, continuous: reload active from shadow (a new P = 0 is rejected: keep old active, `err` = 1). `cnt` = 0, `pulse` = (W != 0).
- `RUN`, `cnt` = P-1, one-shot: go `IDLE`, `pulse` = 0, `busy` = 0, `done` = 1 for one cycle.
- `stop` in any state: go `IDLE`, `pulse`/`busy` = 0 next cycle, no `done`.
- Width rules:
  - Compare is unsigned, CNT_W bits.
  - W = 0 gives a constant-low output that still counts periods.
  - W >= P gives a constant-high output for the whole period.
  - P = 1, W >= 1 in continuous mode gives a constant high.
- Simultaneous events:
  - `stop` beats `start`.
  - `start` while `RUN` is ignored (no retrigger).
  - `cfg_we` to a channel in the same cycle as its `start`: the start uses the new values.
  - `cfg_we` while `RUN`: continuous mode applies it at the next period boundary; one-shot mode ignores it for the current run.
- `rst_n` low mid-run: outputs 0 immediately, independent of `clk`.

## Timing
- `start` sampled at edge t: `pulse` high from t+1 through t+W (W >= 1, W <= P), low until t+P.
- One-shot: `busy` high t+1..t+P; `done` high at t+P+1 cycle only, with `busy` = 0.
- Continuous period is exactly P cycles, with no gap cycle between periods.
- `err` asserts the cycle after the offending `start` or boundary.
- Earliest restart after `done` is a `start` at edge t+P+1, giving `pulse` at t+P+2.

## Structure
- Package `pulse_pkg`: `state_t` enum (`IDLE`, `RUN`), `mode_t` enum (`CONT`, `ONESHOT`), reset-default localparams.
- Sub-module `pulse_channel`, parametrised by `CNT_W`: one FSM, counter, shadow and active registers. The top level decodes `cfg_ch` into per-channel write enables and generate-instantiates `CHANNELS` copies.

## Test plan
- Reset defaults, `start[0]`, continuous: `pulse[0]` reads 1,0,1,0… from t+1. `busy` = 1, `done` = 0.
- Write ch1 P=5 W=2 one-shot, `start[1]` at t: `pulse` high t+1..t+2, low t+3..t+5, `done` at t+6.
- Ch2 P=4 running, write W=3 mid-period: old width holds to the boundary; the next period is high for 3 cycles, low for 1.
- Edge cases on ch3:
  - W=0, P=3: `pulse` never high.
  - W=7, P=3: `pulse` constant 1.
  - P=0 then `start`: `err` one cycle, `busy` stays 0.
- `start` and `stop` together on an idle channel: it stays `IDLE`.
- `stop` mid one-shot: `pulse`/`busy` drop next cycle, no `done`.
- `rst_n` low asynchronously mid-run: outputs drop immediately; after release, ch1 config reads back as defaults (2/1, continuous).
